// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - button-driven mode/speed controller for a 4-LED pattern sequencer
// Buttons are synchronized and debounced; a prescaler paces the pattern FSM.
module led_seq_ctrl #(
   parameter int TICK_DIV   = 50_000_000,
   parameter int DEB_CYCLES = 1_250_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] btn,
   input  logic       en,
   output logic [3:0] led,
   output logic [1:0] mode,
   output logic       fast,
   output logic       tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] SLOW_LAST = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] FAST_LAST = CW'(TICK_DIV / 4 - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      CHASE  = 2'd0,
      BOUNCE = 2'd1,
      BLINK  = 2'd2,
      COUNT  = 2'd3
   } mode_t;

   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    deb;
   logic [1:0]    press;
   logic [DW-1:0] dc [2];

   mode_t         state;
   mode_t         state_nx;
   logic [3:0]    led_nx;
   logic          dir_up;
   logic          dir_up_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic [CW-1:0] cnt_last;
   logic          fast_nx;
   logic          tick_nx;

   // press[i] fires on the cycle after the debounced level rises; releases are silent
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         press <= '0;
         dc[0] <= '0;
         dc[1] <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            press[i] <= 1'b0;
            if (sync2[i] == deb[i]) begin
               dc[i] <= '0;
            end else if (dc[i] == DEB_LAST) begin
               deb[i]   <= sync2[i];
               dc[i]    <= '0;
               press[i] <= sync2[i];
            end else begin
               dc[i] <= dc[i] + DW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= CHASE;
         led    <= 4'b0001;
         dir_up <= 1'b1;
         cnt    <= '0;
         fast   <= 1'b0;
         tick   <= 1'b0;
      end else begin
         state  <= state_nx;
         led    <= led_nx;
         dir_up <= dir_up_nx;
         cnt    <= cnt_nx;
         fast   <= fast_nx;
         tick   <= tick_nx;
      end
   end

   // Priority: mode press, then speed press, then the prescaler step
   always_comb begin
      state_nx  = state;
      led_nx    = led;
      dir_up_nx = dir_up;
      cnt_nx    = cnt;
      fast_nx   = fast;
      tick_nx   = 1'b0;
      cnt_last  = fast ? FAST_LAST : SLOW_LAST;

      if (press[0]) begin
         state_nx  = mode_t'(state + 2'd1);
         cnt_nx    = '0;
         dir_up_nx = 1'b1;
         if (press[1]) begin
            fast_nx = ~fast;
         end
         case (state_nx)
            CHASE:  led_nx = 4'b0001;
            BOUNCE: led_nx = 4'b0001;
            BLINK:  led_nx = 4'b1111;
            COUNT:  led_nx = 4'b0000;
         endcase
      end else if (press[1]) begin
         fast_nx = ~fast;
         cnt_nx  = '0;
      end else if (en) begin
         if (cnt == cnt_last) begin
            cnt_nx  = '0;
            tick_nx = 1'b1;
            case (state)
               CHASE: led_nx = {led[2:0], led[3]};
               BOUNCE: begin
                  if (dir_up) begin
                     if (led[3]) begin
                        dir_up_nx = 1'b0;
                        led_nx    = 4'b0100;
                     end else begin
                        led_nx = {led[2:0], 1'b0};
                     end
                  end else begin
                     if (led[0]) begin
                        dir_up_nx = 1'b1;
                        led_nx    = 4'b0010;
                     end else begin
                        led_nx = {1'b0, led[3:1]};
                     end
                  end
               end
               BLINK: led_nx = ~led;
               COUNT: led_nx = led + 4'd1;
            endcase
         end else begin
            cnt_nx = cnt + CW'(1);
         end
      end
   end

   assign mode = state;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - directed and random checks of led_seq_ctrl against a behavioural model
module tb_led_seq_ctrl;

   localparam int TD = 8;
   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [1:0] btn = 2'b00;
   logic [3:0] led;
   logic [1:0] mode;
   logic       fast;
   logic       tick;

   led_seq_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
      .clk (clk),
      .rst (rst),
      .btn (btn),
      .en  (en),
      .led (led),
      .mode(mode),
      .fast(fast),
      .tick(tick)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model: h[j] is btn sampled j+1 edges ago; a pattern is a position counted from mode entry
   logic [1:0] h [DB+1];
   logic [1:0] mb;
   logic [1:0] mpend;
   int         mm;
   int         mpos;
   int         me;
   logic       mfast;
   logic       mtick;
   logic [3:0] bounce_tab [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};
   logic [3:0] init_tab [4]   = '{4'b0001, 4'b0001, 4'b1111, 4'b0000};

   function automatic logic [3:0] exp_led();
      case (mm)
         0:       return 4'(1 << (mpos % 4));
         1:       return bounce_tab[mpos % 6];
         2:       return ((mpos % 2) == 0) ? 4'hF : 4'h0;
         default: return 4'(mpos % 16);
      endcase
   endfunction

   task automatic model_edge();
      logic [1:0] np;
      int         per;
      logic       all_other;
      if (rst) begin
         for (int j = 0; j <= DB; j++) h[j] = 2'b00;
         mb    = 2'b00;
         mpend = 2'b00;
         mm    = 0;
         mpos  = 0;
         me    = 0;
         mfast = 1'b0;
         mtick = 1'b0;
         return;
      end
      per   = mfast ? TD / 4 : TD;
      mtick = 1'b0;
      if (mpend[0]) begin
         mm   = (mm + 1) % 4;
         mpos = 0;
         me   = 0;
         if (mpend[1]) mfast = ~mfast;
      end else if (mpend[1]) begin
         mfast = ~mfast;
         me    = 0;
      end else if (en) begin
         if (me + 1 == per) begin
            me    = 0;
            mpos  = mpos + 1;
            mtick = 1'b1;
         end else begin
            me = me + 1;
         end
      end
      // a level is accepted once the synchronized input has disagreed for DB straight edges
      np = 2'b00;
      for (int i = 0; i < 2; i++) begin
         all_other = 1'b1;
         for (int j = 1; j <= DB; j++) if (h[j][i] == mb[i]) all_other = 1'b0;
         if (all_other) begin
            np[i] = ~mb[i];
            mb[i] = ~mb[i];
         end
      end
      mpend = np;
      for (int j = DB; j > 0; j--) h[j] = h[j-1];
      h[0] = btn;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check("led",  32'(led),  32'(exp_led()));
      check("mode", 32'(mode), 32'(mm));
      check("fast", 32'(fast), 32'(mfast));
      check("tick", 32'(tick), 32'(mtick));
   endtask

   task automatic press_btn(input int idx, input int hold, input int gap);
      btn[idx] = 1'b1;
      repeat (hold) cycle();
      btn[idx] = 1'b0;
      repeat (gap) cycle();
   endtask

   initial begin
      int n;
      int m_before;

      rst = 1'b1;
      en  = 1'b1;
      btn = 2'b00;
      repeat (3) cycle();
      check("rst_led",  32'(led),  32'h1);
      check("rst_mode", 32'(mode), 32'h0);
      check("rst_fast", 32'(fast), 32'h0);
      check("rst_tick", 32'(tick), 32'h0);
      rst = 1'b0;

      // slow chase: tick every 8 cycles
      repeat (40) cycle();

      // debounce latency: mode changes 6 edges after the raw rise
      btn = 2'b01;
      n = 0;
      m_before = 32'(mode);
      while (n < 30) begin
         cycle();
         if (32'(mode) != m_before) break;
         n++;
      end
      check("press_latency", 32'(n), 32'd6);
      check("bounce_init", 32'(led), 32'h1);
      repeat (13) cycle();
      btn = 2'b00;
      repeat (60) cycle();

      // short glitch is ignored
      m_before = 32'(mode);
      btn = 2'b01;
      repeat (3) cycle();
      btn = 2'b00;
      repeat (20) cycle();
      check("glitch_mode", 32'(mode), 32'(m_before));

      // through BLINK and COUNT back to CHASE
      press_btn(0, 8, 30);
      press_btn(0, 8, 16 * TD + 10);
      press_btn(0, 8, 20);
      check("wrap_mode", 32'(mode), 32'h0);

      // speed toggle on and off
      press_btn(1, 8, 20);
      check("fast_on", 32'(fast), 32'h1);
      press_btn(1, 8, 30);
      check("fast_off", 32'(fast), 32'h0);

      // en low freezes everything
      en = 1'b0;
      repeat (30) cycle();
      en = 1'b1;
      repeat (20) cycle();

      // mode press landing exactly on a step edge
      n = 0;
      while (me != 1 && n < 20) begin
         cycle();
         n++;
      end
      check("collide_sync", 32'(n < 20), 32'h1);
      m_before = 32'(mode);
      btn = 2'b01;
      repeat (7) cycle();
      check("collide_mode", 32'(mode), 32'((m_before + 1) % 4));
      check("collide_tick", 32'(tick), 32'h0);
      check("collide_led",  32'(led),  32'(init_tab[(m_before + 1) % 4]));
      btn = 2'b00;
      repeat (12) cycle();

      // reset in the middle of a debounce
      btn = 2'b01;
      repeat (4) cycle();
      rst = 1'b1;
      btn = 2'b00;
      cycle();
      rst = 1'b0;
      repeat (20) cycle();
      check("rst_deb_mode", 32'(mode), 32'h0);

      // random buttons, enable and occasional reset
      for (int k = 0; k < 160; k++) begin
         btn = 2'($urandom_range(0, 3));
         en  = ($urandom_range(0, 7) != 0);
         rst = ($urandom_range(0, 60) == 0);
         repeat ($urandom_range(1, 14)) cycle();
         rst = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Mode and speed controller for the 4-LED bank on the PYNQ board.
- Two raw pushbuttons select the display pattern and the step rate.
- Owns the step prescaler and sequences the LED pattern state machine.
- Sits between the board button pins and the top-level LED outputs.

Parameters:
TICK_DIV, 50_000_000, prescaler period in clk cycles at slow speed; must be ≥4 and divisible by 4
DEB_CYCLES, 1_250_000, consecutive stable synchronized cycles needed to accept a button level change; must be ≥2

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
btn  input  2  raw asynchronous buttons; btn[0] = next mode, btn[1] = speed toggle; active high
en  input  1  run enable; 0 freezes prescaler and pattern
led  output  4  registered LED drive
mode  output  2  current mode: 0 CHASE, 1 BOUNCE, 2 BLINK, 3 COUNT
fast  output  1  current speed: 0 slow, 1 fast
tick  output  1  one-cycle pulse on each pattern step

Behaviour:
- Reset values (rst high at a posedge):
  - led=4'b0001, mode=0, fast=0, tick=0
  - prescaler=0, direction=up
  - synchronizers, debounced levels and debounce counters = 0
  - rst mid-operation aborts any pending debounce and pattern step.
- Input conditioning, per button, independent:
  - 2-FF synchronizer produces s.
  - Debounced level b and counter dc: if s==b, dc<=0. Otherwise, if dc==DEB_CYCLES-1, then b<=s and dc<=0; else dc<=dc+1.
  - On the edge where b goes 0→1, press register <=1 for exactly one cycle. Release (1→0) produces no pulse.
  - Latency: raw rises before edge 0 → b set at edge DEB_CYCLES+1 → press high after it → mode/fast update at edge DEB_CYCLES+2.
  - Glitches shorter than DEB_CYCLES synchronized cycles are ignored.
- Prescaler:
  - Period P = TICK_DIV when fast=0, TICK_DIV/4 when fast=1. Counter runs 0..P-1 while en=1.
  - At the edge where cnt==P-1 and en=1: cnt<=0, tick<=1 and the pattern advances, so led and tick change on the same edge.
  - Otherwise tick<=0.
  - en=0: cnt, led and direction hold; tick=0.
- Pattern FSM, advance on step:
  - CHASE: 0001→0010→0100→1000→0001.
  - BOUNCE: shift left while direction=up. At 1000, switch direction to down and go to 0100. At 0001 going down, switch direction to up and go to 0010. Sequence: 0001,0010,0100,1000,0100,0010,0001,0010…
  - BLINK: 0000↔1111.
  - COUNT: binary led+1, 1111 wraps to 0000.
- Mode press:
  - mode<=mode+1, wrapping 3→0.
  - led<=initial value of the new mode: CHASE 0001, BOUNCE 0001 with direction up, BLINK 1111, COUNT 0000.
  - cnt<=0, tick<=0.
  - Accepted regardless of en.
- Speed press: fast<=~fast, cnt<=0; led unchanged.
- Simultaneous events, priority high→low: rst, mode press, speed press, step.
  - Mode press on the same edge as a step: the step is discarded.
  - Mode and speed press on the same edge: both apply, and cnt<=0.
- Arithmetic: all counters unsigned, width $clog2 of their range; no overflow beyond the stated wraps.

Test Plan (TICK_DIV=8, DEB_CYCLES=4 unless noted):
- Reset, en=1, no buttons → led 0001 after reset; tick pulses every 8 cycles; led 0010, 0100, 1000, 0001 on ticks 1–4.
- btn[0] held high 20 cycles, en=1 → mode 0→1 exactly 6 edges after raw rise; led 0001; next 7 ticks give 0010,0100,1000,0100,0010,0001,0010.
- btn[0] high for only 3 cycles, then low → no mode change, press never asserted; pattern continues uninterrupted.
- Four accepted btn[0] presses → mode sequence 1,2,3,0. BLINK starts at 1111 then 0000,1111. COUNT starts at 0000; 16 ticks return led to 0000 via 1111.
- btn[1] press → fast=1, cnt cleared, tick period becomes 2 cycles. Second press → fast=0, period 8.
- Negative paths:
  - en=0 for 30 cycles → no tick, led frozen; en back to 1 resumes from the held cnt value.
  - Mode press timed on the tick edge → led = new mode initial value, no step that cycle.
  - rst asserted mid-debounce → no press afterwards.
